// File: rtl/instruction_decoder.sv
// RV32I instruction decoder: one 32-bit word in, one 65-bit decoded bundle out.
// Latency: exactly 1 cycle (combinational decode, registered on every clk edge).
// Backpressure: none; a new word is accepted and decoded every cycle.
module instruction_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_in,
    output logic [64:0] instruction_out
);

    // op_class encodings
    localparam logic [3:0] CLS_LUI    = 4'd1;
    localparam logic [3:0] CLS_AUIPC  = 4'd2;
    localparam logic [3:0] CLS_JAL    = 4'd3;
    localparam logic [3:0] CLS_JALR   = 4'd4;
    localparam logic [3:0] CLS_BRANCH = 4'd5;
    localparam logic [3:0] CLS_LOAD   = 4'd6;
    localparam logic [3:0] CLS_STORE  = 4'd7;
    localparam logic [3:0] CLS_OP_IMM = 4'd8;
    localparam logic [3:0] CLS_OP     = 4'd9;
    localparam logic [3:0] CLS_FENCE  = 4'd10;
    localparam logic [3:0] CLS_SYSTEM = 4'd11;

    // alu_op encodings
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // raw instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd_f, rs1_f, rs2_f;
    logic [2:0]  f3_f;
    logic [6:0]  f7_f;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instruction_in[6:0];
    assign rd_f   = instruction_in[11:7];
    assign f3_f   = instruction_in[14:12];
    assign rs1_f  = instruction_in[19:15];
    assign rs2_f  = instruction_in[24:20];
    assign f7_f   = instruction_in[31:25];

    assign imm_i = {{20{instruction_in[31]}}, instruction_in[31:20]};
    assign imm_s = {{20{instruction_in[31]}}, instruction_in[31:25], instruction_in[11:7]};
    assign imm_b = {{19{instruction_in[31]}}, instruction_in[31], instruction_in[7],
                    instruction_in[30:25], instruction_in[11:8], 1'b0};
    assign imm_u = {instruction_in[31:12], 12'h000};
    assign imm_j = {{11{instruction_in[31]}}, instruction_in[31], instruction_in[19:12],
                    instruction_in[20], instruction_in[30:21], 1'b0};

    // decoded fields before the illegal squash
    logic [3:0]  op_class;
    logic [3:0]  alu_op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        writes_rd, use_imm, use_pc, mem_rd, mem_wr, is_branch, illegal;
    logic [3:0]  arith_alu;
    logic [64:0] decoded;

    // funct3/funct7 to ALU operation for OP and OP_IMM; funct7[5] picks SUB/SRA
    always_comb begin
        arith_alu = ALU_ADD;
        case (f3_f)
            3'b000: arith_alu = (opcode[5] && f7_f[5]) ? ALU_SUB : ALU_ADD;
            3'b001: arith_alu = ALU_SLL;
            3'b010: arith_alu = ALU_SLT;
            3'b011: arith_alu = ALU_SLTU;
            3'b100: arith_alu = ALU_XOR;
            3'b101: arith_alu = f7_f[5] ? ALU_SRA : ALU_SRL;
            3'b110: arith_alu = ALU_OR;
            default: arith_alu = ALU_AND;
        endcase
    end

    // per-opcode decode: class, operand selects, register field masking, legality
    always_comb begin
        op_class  = 4'd0;
        alu_op    = ALU_ADD;
        rd        = rd_f;
        rs1       = rs1_f;
        rs2       = rs2_f;
        funct3    = f3_f;
        imm       = 32'h0;
        writes_rd = 1'b0;
        use_imm   = 1'b0;
        use_pc    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        is_branch = 1'b0;
        illegal   = (opcode[1:0] != 2'b11);
        case (opcode[6:2])
            5'b01101: begin
                op_class = CLS_LUI;   imm = imm_u; use_imm = 1'b1; writes_rd = 1'b1;
                rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0;
            end
            5'b00101: begin
                op_class = CLS_AUIPC; imm = imm_u; use_imm = 1'b1; use_pc = 1'b1; writes_rd = 1'b1;
                rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0;
            end
            5'b11011: begin
                op_class = CLS_JAL;   imm = imm_j; use_imm = 1'b1; use_pc = 1'b1; writes_rd = 1'b1;
                rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0;
            end
            5'b11001: begin
                op_class = CLS_JALR;  imm = imm_i; use_imm = 1'b1; writes_rd = 1'b1; rs2 = 5'd0;
                if (f3_f != 3'd0) illegal = 1'b1;
            end
            5'b11000: begin
                op_class = CLS_BRANCH; imm = imm_b; is_branch = 1'b1; alu_op = ALU_SUB; rd = 5'd0;
                if (f3_f == 3'd2 || f3_f == 3'd3) illegal = 1'b1;
            end
            5'b00000: begin
                op_class = CLS_LOAD;  imm = imm_i; use_imm = 1'b1; mem_rd = 1'b1; writes_rd = 1'b1;
                rs2 = 5'd0;
                if (f3_f == 3'd3 || f3_f == 3'd6 || f3_f == 3'd7) illegal = 1'b1;
            end
            5'b01000: begin
                op_class = CLS_STORE; imm = imm_s; use_imm = 1'b1; mem_wr = 1'b1; rd = 5'd0;
                if (f3_f > 3'd2) illegal = 1'b1;
            end
            5'b00100: begin
                op_class = CLS_OP_IMM; imm = imm_i; use_imm = 1'b1; writes_rd = 1'b1;
                alu_op = arith_alu; rs2 = 5'd0;
                if (f3_f == 3'b001 && f7_f != 7'h00) illegal = 1'b1;
                if (f3_f == 3'b101 && f7_f != 7'h00 && f7_f != 7'h20) illegal = 1'b1;
            end
            5'b01100: begin
                op_class = CLS_OP; writes_rd = 1'b1; alu_op = arith_alu;
                if (f7_f != 7'h00 && f7_f != 7'h20) illegal = 1'b1;
                if (f7_f == 7'h20 && f3_f != 3'b000 && f3_f != 3'b101) illegal = 1'b1;
            end
            5'b00011: begin
                op_class = CLS_FENCE; rs2 = 5'd0;
            end
            5'b11100: begin
                // CSR forms (funct3 != 0) write rd; ECALL/EBREAK do not
                op_class = CLS_SYSTEM; imm = imm_i; rs2 = 5'd0; writes_rd = (f3_f != 3'd0);
                if (f3_f == 3'b100) illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // assemble the bundle; an illegal word collapses to just the illegal flag
    always_comb begin
        if (illegal) begin
            decoded = {1'b1, 64'h0};
        end else begin
            decoded = {1'b0, op_class, funct3, alu_op, rd, rs1, rs2, imm,
                       writes_rd && (rd != 5'd0), use_imm, use_pc, mem_rd, mem_wr, is_branch};
        end
    end

    // register the bundle every cycle; reset wins over the incoming word
    always_ff @(posedge clk) begin
        if (rst) instruction_out <= 65'h0;
        else     instruction_out <= decoded;
    end

endmodule

// File: tb/tb_instruction_decoder.sv
// Bench for instruction_decoder: directed ISA examples plus random words
// compared against a field-level reference model of RV32I decode.
// Outputs are sampled 1 time unit after the rising edge; inputs change on the falling edge.
`timescale 1ns/1ps
module tb_instruction_decoder;

    logic        clk;
    logic        rst;
    logic [31:0] instruction_in;
    logic [64:0] instruction_out;

    int checks = 0;
    int errors = 0;

    localparam logic [64:0] ILLEGAL_BUNDLE = {1'b1, 64'h0};

    instruction_decoder dut (
        .clk            (clk),
        .rst            (rst),
        .instruction_in (instruction_in),
        .instruction_out(instruction_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: builds the bundle from named fields per RV32I rules.
    function automatic logic [64:0] model(input logic [31:0] w);
        logic [3:0]  cls, alu;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm, ii, is, ib, iu, ij;
        logic        wr, ui, up, mr, mw, br, ill;
        int          alu_tab [8];
        alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
        f3 = w[14:12]; f7 = w[31:25];
        rd = w[11:7];  rs1 = w[19:15]; rs2 = w[24:20];
        ii = $signed(w) >>> 20;
        is = (ii & ~32'h1F) | 32'(w[11:7]);
        ib = (w[31] ? -32'd4096 : 32'd0) + (32'(w[7]) << 11) + (32'(w[30:25]) << 5) + (32'(w[11:8]) << 1);
        iu = w & 32'hFFFFF000;
        ij = (w[31] ? -32'd1048576 : 32'd0) + (32'(w[19:12]) << 12) + (32'(w[20]) << 11) + (32'(w[30:21]) << 1);
        cls = 0; alu = 0; imm = 0; wr = 0; ui = 0; up = 0; mr = 0; mw = 0; br = 0; ill = 0;
        if (w[1:0] != 2'b11) ill = 1;
        else begin
            case (w[6:0])
                7'b0110111: begin cls = 1; rs1 = 0; rs2 = 0; f3 = 0; imm = iu; ui = 1; wr = 1; end
                7'b0010111: begin cls = 2; rs1 = 0; rs2 = 0; f3 = 0; imm = iu; ui = 1; up = 1; wr = 1; end
                7'b1101111: begin cls = 3; rs1 = 0; rs2 = 0; f3 = 0; imm = ij; ui = 1; up = 1; wr = 1; end
                7'b1100111: begin cls = 4; rs2 = 0; imm = ii; ui = 1; wr = 1; ill = (f3 != 0); end
                7'b1100011: begin cls = 5; rd = 0; imm = ib; br = 1; alu = 1; ill = (f3 == 2 || f3 == 3); end
                7'b0000011: begin cls = 6; rs2 = 0; imm = ii; ui = 1; mr = 1; wr = 1; ill = (f3 == 3 || f3 >= 6); end
                7'b0100011: begin cls = 7; rd = 0; imm = is; ui = 1; mw = 1; ill = (f3 > 2); end
                7'b0010011: begin
                    cls = 8; rs2 = 0; imm = ii; ui = 1; wr = 1; alu = 4'(alu_tab[f3]);
                    if (f3 == 5 && f7 == 7'h20) alu = 7;
                    if (f3 == 1 && f7 != 0) ill = 1;
                    if (f3 == 5 && f7 != 0 && f7 != 7'h20) ill = 1;
                end
                7'b0110011: begin
                    cls = 9; wr = 1; alu = 4'(alu_tab[f3]);
                    if (f7 == 7'h20 && f3 == 0) alu = 1;
                    if (f7 == 7'h20 && f3 == 5) alu = 7;
                    if (f7 != 0 && f7 != 7'h20) ill = 1;
                    if (f7 == 7'h20 && f3 != 0 && f3 != 5) ill = 1;
                end
                7'b0001111: begin cls = 10; rs2 = 0; end
                7'b1110011: begin cls = 11; rs2 = 0; imm = ii; wr = (f3 != 0); ill = (f3 == 4); end
                default: ill = 1;
            endcase
        end
        if (ill) return ILLEGAL_BUNDLE;
        return {1'b0, cls, f3, alu, rd, rs1, rs2, imm, wr && (rd != 0), ui, up, mr, mw, br};
    endfunction

    // Random word: sometimes fully random, usually a valid opcode with random fields.
    function automatic logic [31:0] gen_word();
        logic [6:0] ops [11];
        logic [31:0] w;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        w = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            w[6:0] = ops[$urandom_range(0, 10)];
            case ($urandom_range(0, 2))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                default: ;
            endcase
        end
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk) instruction_in = $urandom;
            @(posedge clk); #1;
            checks++;
            if (instruction_out !== 65'h0) begin
                errors++;
                $display("FAIL reset[%0d]: got %h want %h", i, instruction_out, 65'h0);
            end
        end
        @(negedge clk) begin rst = 1'b0; instruction_in = 32'h00000013; end
        @(posedge clk); #1;
        checks++;
        if (instruction_out[63:60] !== 4'd8 || instruction_out[56:53] !== 4'd0 ||
            instruction_out[4] !== 1'b1 || instruction_out[5] !== 1'b0 || instruction_out[64] !== 1'b0) begin
            errors++;
            $display("FAIL nop_after_reset: got %h want class 8 ADD use_imm rd_we=0", instruction_out);
        end
    endtask

    // Applies one word and checks the registered bundle, plus optional field constants.
    task automatic apply_check(input string name, input logic [31:0] w);
        @(negedge clk) instruction_in = w;
        @(posedge clk); #1;
        checks++;
        if (instruction_out !== model(w)) begin
            errors++;
            $display("FAIL %s: in %h got %h want %h", name, w, instruction_out, model(w));
        end
    endtask

    task automatic test_directed();
        logic [64:0] prev;
        prev = model(32'h00000013);
        // ADDI: output must not change before the edge, then appear right after it
        @(negedge clk) instruction_in = 32'hFFF10093;
        #4;
        checks++;
        if (instruction_out !== prev) begin
            errors++;
            $display("FAIL addi_early: got %h want %h", instruction_out, prev);
        end
        @(posedge clk); #1;
        checks++;
        if (instruction_out[63:60] !== 4'd8 || instruction_out[52:48] !== 5'd1 ||
            instruction_out[47:43] !== 5'd2 || instruction_out[37:6] !== 32'hFFFFFFFF ||
            instruction_out[5] !== 1'b1 || instruction_out[4] !== 1'b1 || instruction_out[64] !== 1'b0) begin
            errors++;
            $display("FAIL addi_fields: got %h", instruction_out);
        end
        apply_check("sub", 32'h405201B3);
        checks++;
        if (instruction_out[63:60] !== 4'd9 || instruction_out[56:53] !== 4'd1 || instruction_out[42:38] !== 5'd5) begin
            errors++;
            $display("FAIL sub_fields: got %h want class 9 SUB rs2=5", instruction_out);
        end
        apply_check("sra", 32'h405251B3);
        checks++;
        if (instruction_out[56:53] !== 4'd7) begin
            errors++;
            $display("FAIL sra_alu: got %0d want 7", instruction_out[56:53]);
        end
        apply_check("bad_f7", 32'h405211B3);
        checks++;
        if (instruction_out !== ILLEGAL_BUNDLE) begin
            errors++;
            $display("FAIL bad_f7_illegal: got %h want %h", instruction_out, ILLEGAL_BUNDLE);
        end
        apply_check("beq", 32'hFE208EE3);
        checks++;
        if (instruction_out[63:60] !== 4'd5 || instruction_out[0] !== 1'b1 ||
            instruction_out[37:6] !== 32'hFFFFFFFC || instruction_out[52:48] !== 5'd0) begin
            errors++;
            $display("FAIL beq_fields: got %h", instruction_out);
        end
        apply_check("sw", 32'h00532423);
        checks++;
        if (instruction_out[63:60] !== 4'd7 || instruction_out[1] !== 1'b1 ||
            instruction_out[37:6] !== 32'd8 || instruction_out[5] !== 1'b0) begin
            errors++;
            $display("FAIL sw_fields: got %h", instruction_out);
        end
        apply_check("lui", 32'h123453B7);
        checks++;
        if (instruction_out[37:6] !== 32'h12345000) begin
            errors++;
            $display("FAIL lui_imm: got %h want 12345000", instruction_out[37:6]);
        end
        apply_check("jal", 32'h001000EF);
        checks++;
        if (instruction_out[63:60] !== 4'd3 || instruction_out[37:6] !== 32'h800 ||
            instruction_out[3] !== 1'b1 || instruction_out[5] !== 1'b1) begin
            errors++;
            $display("FAIL jal_fields: got %h", instruction_out);
        end
        apply_check("zero", 32'h00000000);
        checks++;
        if (instruction_out !== ILLEGAL_BUNDLE) begin
            errors++;
            $display("FAIL zero_illegal: got %h want %h", instruction_out, ILLEGAL_BUNDLE);
        end
        apply_check("ones", 32'hFFFFFFFF);
        checks++;
        if (instruction_out !== ILLEGAL_BUNDLE) begin
            errors++;
            $display("FAIL ones_illegal: got %h want %h", instruction_out, ILLEGAL_BUNDLE);
        end
    endtask

    // Consecutive random words, one per cycle, each expected on the next edge.
    task automatic test_back_to_back();
        logic [31:0] w;
        for (int i = 0; i < 400; i++) begin
            w = gen_word();
            @(negedge clk) instruction_in = w;
            @(posedge clk); #1;
            checks++;
            if (instruction_out !== model(w)) begin
                errors++;
                $display("FAIL b2b[%0d]: in %h got %h want %h", i, w, instruction_out, model(w));
            end
        end
    endtask

    // Reset asserted with a legal word present must still clear the output.
    task automatic test_reset_override();
        @(negedge clk) begin rst = 1'b1; instruction_in = 32'hFFF10093; end
        @(posedge clk); #1;
        checks++;
        if (instruction_out !== 65'h0) begin
            errors++;
            $display("FAIL reset_override: got %h want 0", instruction_out);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (instruction_out !== model(32'hFFF10093)) begin
            errors++;
            $display("FAIL after_reset_release: got %h want %h", instruction_out, model(32'hFFF10093));
        end
    endtask

    initial begin
        rst = 1'b1;
        instruction_in = 32'h0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_override();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
